// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: the canonical NOP encoding and the
// {pc, instr} pair that travels from fetch into IF/ID.
package rv32_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count; dout shows
// the head entry combinationally. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; clear beats push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem request/response tracking, fetch
// buffer and IF/ID register. Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed_insts
`endif
);

  import rv32_pkg::*;

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = $bits(fetch_entry_t);

  logic [31:0]   pc_q;
  logic [31:0]   redirect_pc;
  logic [31:0]   pend_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] pend_cnt;
  logic [CW:0]   credit_used;
  logic          grant;
  logic          rvalid_ok;
  logic          dropping;
  logic          buf_push;
  logic          buf_pop;
  fetch_entry_t  buf_in;
  fetch_entry_t  buf_head;
  logic [EW-1:0] buf_dout;
  logic          valid_q;
  logic [31:0]   pc_id_q;
  logic [31:0]   instr_q;

  assign redirect_pc = branch_target & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  // Requests are held off during reset so nothing is granted before state is valid.
  assign imem_req    = rstn && !flush && (credit_used < CW1'(FIFO_DEPTH));
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;
  assign rvalid_ok   = imem_rvalid && (out_cnt != '0);
  assign dropping    = rvalid_ok && (drop_cnt != '0);
  assign buf_push    = rvalid_ok && !dropping && !flush;
  assign buf_pop     = !flush && !stall && (fifo_cnt != '0);
  assign buf_in      = '{pc: pend_pc, instr: imem_rdata};
  assign buf_head    = buf_dout;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pend_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (grant),
    .pop   (rvalid_ok),
    .clear (1'b0),
    .din   (pc_q),
    .dout  (pend_pc),
    .count (pend_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fetch_buf (
    .clk   (clk),
    .rstn  (rstn),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (flush),
    .din   (buf_in),
    .dout  (buf_dout),
    .count (fifo_cnt)
  );

  // Responses already marked for dropping are still part of out_cnt, so after a
  // flush everything still outstanding is exactly what must be discarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(grant) - CW'(rvalid_ok);
      if (flush) begin
        pc_q     <= redirect_pc;
        drop_cnt <= out_cnt - CW'(rvalid_ok);
      end else begin
        if (grant)    pc_q     <= pc_q + 32'd4;
        if (dropping) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      pc_id_q <= '0;
      instr_q <= RV32_NOP;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (buf_pop) begin
        valid_q <= 1'b1;
        pc_id_q <= buf_head.pc;
        instr_q <= buf_head.instr;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign if_id_valid = valid_q;
  assign if_id_pc    = pc_id_q;
  assign if_id_instr = valid_q ? instr_q : RV32_NOP;

`ifdef FETCH_PERF_CNT_EN
  localparam int PW = CW + 2;

  logic [PW-1:0] flushed_now;
  logic [32:0]   flushed_sum;

  // A response arriving in the flush cycle with nothing to drop dies with the buffer.
  always_comb begin
    flushed_now = PW'(dropping);
    if (flush) begin
      flushed_now = flushed_now + PW'(fifo_cnt) + PW'(valid_q) + PW'(rvalid_ok && !dropping);
    end
  end

  assign flushed_sum = {1'b0, perf_flushed_insts} + 33'(flushed_now);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cycles  <= '0;
      perf_flushed_insts <= '0;
    end else begin
      if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      perf_flushed_insts <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rstn)
    imem_rvalid |-> (out_cnt != '0));
  a_buf_push_not_full: assert property (@(posedge clk) disable iff (!rstn)
    buf_push |-> (fifo_cnt < CW'(FIFO_DEPTH)));
  a_pend_tracks_out: assert property (@(posedge clk) disable iff (!rstn)
    pend_cnt == out_cnt);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a responder memory returns addr^0xA5A5_0000
// and every granted address is expected to reach IF/ID in order unless flushed.
module tb_fetch_stage;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY    = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushed_insts;
`endif

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          mem_lat = 1;
  logic        prev_stall  = 1'b0;
  logic        prev_flush  = 1'b0;
  logic        model_valid = 1'b0;
  logic [31:0] model_pc    = '0;
  logic [31:0] sb_e;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_flushed_insts (perf_flushed_insts)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] bt, input logic g);
    @(posedge clk);
    #1;
    stall         = s;
    flush         = f;
    branch_target = bt;
    imem_gnt      = g;
  endtask

  // Memory responder: in-order, each response no earlier than its due cycle.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
      end else begin
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_q[0].addr ^ XOR_KEY;
          void'(mem_q.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard: IF/ID observed mid-cycle reflects the edge governed by last cycle's stall/flush.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        prev_stall  = 1'b0;
        prev_flush  = 1'b0;
        model_valid = 1'b0;
      end else begin
        if (prev_flush) begin
          checkOutput("flush_kill", 32'(if_id_valid), 32'd0);
          model_valid = 1'b0;
        end else if (prev_stall) begin
          checkOutput("stall_hold_valid", 32'(if_id_valid), 32'(model_valid));
          if (model_valid) checkOutput("stall_hold_pc", if_id_pc, model_pc);
        end else if (exp_q.size() == 0) begin
          checkOutput("sb_extra_valid", 32'(if_id_valid), 32'd0);
          model_valid = 1'b0;
        end else if (if_id_valid) begin
          sb_e = exp_q.pop_front();
          checkOutput("sb_pc", if_id_pc, sb_e);
          checkOutput("sb_instr", if_id_instr, sb_e ^ XOR_KEY);
          model_valid = 1'b1;
          model_pc    = sb_e;
        end else begin
          model_valid = 1'b0;
        end
        if (!if_id_valid) checkOutput("nop_when_invalid", if_id_instr, NOP);
        if (flush) exp_q.delete();
        if (imem_req && imem_gnt) begin
          exp_q.push_back(imem_addr);
          mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
          checkOutput("outstanding_le_depth", 32'(mem_q.size() <= FIFO_DEPTH), 32'd1);
        end
        prev_stall = stall;
        prev_flush = flush;
      end
    end
  end

  initial begin
    int gap;
    rstn          = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_target = '0;
    imem_gnt      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
    checkOutput("rst_pc", if_id_pc, 32'd0);
    checkOutput("rst_instr", if_id_instr, NOP);
    checkOutput("rst_addr", imem_addr, 32'd0);

    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("c0_req", 32'(imem_req), 32'd1);
    checkOutput("c0_addr", imem_addr, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("lat_valid", 32'(if_id_valid), 32'(i >= 3));
      if (i >= 3) checkOutput("lat_pc", if_id_pc, 32'(4 * (i - 3)));
    end

    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stall_first_pc", if_id_pc, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i < 2, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("stall_frozen_pc", if_id_pc, 32'h10);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stall_next_pc", if_id_pc, 32'h14);
    checkOutput("stall_next_valid", 32'(if_id_valid), 32'd1);

    mem_lat = 2;
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
    @(negedge clk);
    checkOutput("flush_req_low", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("redirect_addr", imem_addr, 32'h200);
    gap = 0;
    while (!if_id_valid && gap < 20) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      gap++;
    end
    checkOutput("redirect_first_valid", 32'(if_id_valid), 32'd1);
    checkOutput("redirect_first_pc", if_id_pc, 32'h200);
    checkOutput("redirect_latency_min", 32'(gap >= 2), 32'd1);

    repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    mem_lat = 3;
    repeat (25) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    mem_lat = 1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("misaligned_target", imem_addr, 32'h100);
    repeat (8) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_start", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("pc_wrap", imem_addr, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    repeat (8) applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stall_credit_block", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(if_id_valid), 32'd0);
    checkOutput("arst_pc", if_id_pc, 32'd0);
    checkOutput("arst_instr", if_id_instr, NOP);
    checkOutput("arst_req", 32'(imem_req), 32'd0);
    checkOutput("arst_addr", imem_addr, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("refetch_req", 32'(imem_req), 32'd1);
    checkOutput("refetch_addr", imem_addr, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (i >= 3) checkOutput("refetch_pc", if_id_pc, 32'(4 * (i - 3)));
    end

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    gap = 0;
    while (exp_q.size() != 0 && gap < 40) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      gap++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
